mu0_control: RTL and testbench

MU0 control unit: a fetch/execute state machine that sequences the 16-bit MU0 datapath, including the 16-bit 2:1 operand/address multiplexers, the ALU, the PC/IR/ACC registers and the memory strobes. It decodes the 4-bit opcode held in IR and uses the accumulator flags N and Z. It drives every mux select, register enable and memory strobe in the processor. It also maintains a retired-instruction counter for debug.

---
 rtl/mu0_pkg.sv | 43 ++++
 rtl/mu0_decode.sv | 58 +++++
 rtl/mu0_control.sv | 97 +++++++++
 tb/tb_mu0_control.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared MU0 encodings: opcodes, ALU function codes, control-unit states and the control word.
package mu0_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned ALU_FS_W = 2;
    localparam int unsigned CNT_W    = 16;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_STA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_JMP = 4'h4;
    localparam logic [OP_W-1:0] OP_JGE = 4'h5;
    localparam logic [OP_W-1:0] OP_JNE = 4'h6;
    localparam logic [OP_W-1:0] OP_STP = 4'h7;

    localparam logic [ALU_FS_W-1:0] ALU_PASSY = 2'b00;
    localparam logic [ALU_FS_W-1:0] ALU_ADD   = 2'b01;
    localparam logic [ALU_FS_W-1:0] ALU_INC   = 2'b10;
    localparam logic [ALU_FS_W-1:0] ALU_SUB   = 2'b11;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        HALT    = 2'b10
    } state_t;

    // mem_access marks cycles that may be stretched by memory wait states
    typedef struct packed {
        logic                x_sel;
        logic                y_sel;
        logic                addr_sel;
        logic [ALU_FS_W-1:0] alu_fs;
        logic                pc_en;
        logic                ir_en;
        logic                acc_en;
        logic                mem_ren;
        logic                mem_wen;
        logic                halted;
        logic                mem_access;
    } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational MU0 decoder: state, opcode and ACC flags to the raw control word.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] f,
    input  logic            n,
    input  logic            z,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_ren    = 1'b1;
                ctrl.ir_en      = 1'b1;
                ctrl.x_sel      = 1'b1;
                ctrl.alu_fs     = ALU_INC;
                ctrl.pc_en      = 1'b1;
                ctrl.mem_access = 1'b1;
            end
            EXECUTE: begin
                case (f)
                    OP_LDA: begin
                        ctrl.addr_sel   = 1'b1;
                        ctrl.mem_ren    = 1'b1;
                        ctrl.alu_fs     = ALU_PASSY;
                        ctrl.acc_en     = 1'b1;
                        ctrl.mem_access = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.addr_sel   = 1'b1;
                        ctrl.mem_wen    = 1'b1;
                        ctrl.mem_access = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.addr_sel   = 1'b1;
                        ctrl.mem_ren    = 1'b1;
                        ctrl.alu_fs     = (f == OP_ADD) ? ALU_ADD : ALU_SUB;
                        ctrl.acc_en     = 1'b1;
                        ctrl.mem_access = 1'b1;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        ctrl.y_sel  = 1'b1;
                        ctrl.alu_fs = ALU_PASSY;
                        ctrl.pc_en  = (f == OP_JMP) ? 1'b1 :
                                      (f == OP_JGE) ? ~n : ~z;
                    end
                    default: ;
                endcase
            end
            HALT:    ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute sequencer, memory wait handling and retired-instruction counter.
// Optional memory wait states are enabled by defining MU0_MEM_WAIT_EN.
module mu0_control
    import mu0_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     F,
    input  logic                N,
    input  logic                Z,
`ifdef MU0_MEM_WAIT_EN
    input  logic                mem_ready,
`endif
    output logic                X_sel,
    output logic                Y_sel,
    output logic                Addr_sel,
    output logic [ALU_FS_W-1:0] ALU_fs,
    output logic                PC_En,
    output logic                IR_En,
    output logic                Acc_En,
    output logic                MEM_ren,
    output logic                MEM_wen,
    output logic                Halted,
    output logic [CNT_W-1:0]    instr_count
);

    state_t     state;
    state_t     next_state;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;
    logic       mem_ready_c;
    logic       stall;
    logic       retire;

`ifdef MU0_MEM_WAIT_EN
    assign mem_ready_c = mem_ready;
`else
    assign mem_ready_c = 1'b1;
`endif

    mu0_decode u_decode (
        .state (state),
        .f     (F),
        .n     (N),
        .z     (Z),
        .ctrl  (dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Stalls keep selects and strobes up but suppress register loads
    always_comb begin
        next_state = state;
        ctrl       = dec_ctrl;
        stall      = dec_ctrl.mem_access & ~mem_ready_c;
        retire     = 1'b0;
        case (state)
            FETCH:   if (!stall) next_state = EXECUTE;
            EXECUTE: begin
                if (!stall) begin
                    retire     = 1'b1;
                    next_state = (F == OP_STP) ? HALT : FETCH;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
        if (stall) begin
            ctrl.pc_en  = 1'b0;
            ctrl.ir_en  = 1'b0;
            ctrl.acc_en = 1'b0;
        end
        if (reset)
            ctrl = '0;
    end

    assign X_sel    = ctrl.x_sel;
    assign Y_sel    = ctrl.y_sel;
    assign Addr_sel = ctrl.addr_sel;
    assign ALU_fs   = ctrl.alu_fs;
    assign PC_En    = ctrl.pc_en;
    assign IR_En    = ctrl.ir_en;
    assign Acc_En   = ctrl.acc_en;
    assign MEM_ren  = ctrl.mem_ren;
    assign MEM_wen  = ctrl.mem_wen;
    assign Halted   = ctrl.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: vector table plus scoreboard queue and multi-cycle sequences.
module tb_mu0_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  F = 4'h0;
    logic        N = 1'b0;
    logic        Z = 1'b0;
    logic        mem_ready = 1'b1;
    logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_ren, MEM_wen, Halted;
    logic [1:0]  ALU_fs;
    logic [15:0] instr_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'h0000;

    typedef struct {
        string       name;
        logic [3:0]  f;
        logic        n;
        logic        z;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    vec_t vecs[13];
    sb_t  sb_q[$];

    mu0_control dut (
        .clk         (clk),
        .reset       (reset),
        .F           (F),
        .N           (N),
        .Z           (Z),
`ifdef MU0_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .X_sel       (X_sel),
        .Y_sel       (Y_sel),
        .Addr_sel    (Addr_sel),
        .ALU_fs      (ALU_fs),
        .PC_En       (PC_En),
        .IR_En       (IR_En),
        .Acc_En      (Acc_En),
        .MEM_ren     (MEM_ren),
        .MEM_wen     (MEM_wen),
        .Halted      (Halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    wire [11:0] act = {X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En,
                       MEM_ren, MEM_wen, Halted, 1'b0};

    // Control word layout: x y addr fs[1:0] pc ir acc ren wen halted pad
    function automatic logic [11:0] cw(bit x, bit y, bit a, bit [1:0] fs, bit pc, bit ir,
                                       bit acc, bit ren, bit wen, bit h);
        return {x, y, a, fs, pc, ir, acc, ren, wen, h, 1'b0};
    endfunction

    localparam logic [11:0] W_ZERO = 12'h000;
    logic [11:0] w_fetch;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string nm, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: ctrl actual=%03h required=%03h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string nm);
        n_cmp++;
        if (instr_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL %s: instr_count actual=%04h required=%04h (t=%0t)", nm, instr_count, exp_cnt, $time);
        end
    endtask

    task automatic sb_pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: actual=empty required=entry");
        end else begin
            e = sb_q.pop_front();
            check_w(e.name, e.exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w_fetch = cw(1, 0, 0, 2'b10, 1, 1, 0, 1, 0, 0);
        vecs[0]  = '{"lda",       4'h0, 1'b0, 1'b0, cw(0, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0)};
        vecs[1]  = '{"sta",       4'h1, 1'b0, 1'b0, cw(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0)};
        vecs[2]  = '{"add",       4'h2, 1'b0, 1'b0, cw(0, 0, 1, 2'b01, 0, 0, 1, 1, 0, 0)};
        vecs[3]  = '{"sub",       4'h3, 1'b0, 1'b0, cw(0, 0, 1, 2'b11, 0, 0, 1, 1, 0, 0)};
        vecs[4]  = '{"jmp",       4'h4, 1'b0, 1'b0, cw(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0)};
        vecs[5]  = '{"jmp_flags", 4'h4, 1'b1, 1'b1, cw(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0)};
        vecs[6]  = '{"jge_n1",    4'h5, 1'b1, 1'b0, cw(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{"jge_n0",    4'h5, 1'b0, 1'b1, cw(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0)};
        vecs[8]  = '{"jne_z1",    4'h6, 1'b0, 1'b1, cw(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"jne_z0",    4'h6, 1'b1, 1'b0, cw(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0)};
        vecs[10] = '{"nop_8",     4'h8, 1'b0, 1'b0, W_ZERO};
        vecs[11] = '{"nop_f",     4'hF, 1'b1, 1'b1, W_ZERO};
        vecs[12] = '{"lda_n1",    4'h0, 1'b1, 1'b1, cw(0, 0, 1, 2'b00, 0, 0, 1, 1, 0, 0)};

        // Reset held two cycles: all enables, strobes and Halted low
        reset = 1'b1;
        step();
        check_w("rst_c1", W_ZERO);
        step();
        check_w("rst_c2", W_ZERO);
        reset = 1'b0;
        #1;
        check_w("fetch0", w_fetch);
        check_cnt("cnt0");

        foreach (vecs[i]) begin
            check_w("fetch", w_fetch);
            check_cnt("cnt_fetch");
            F = vecs[i].f;
            N = vecs[i].n;
            Z = vecs[i].z;
            sb_q.push_back('{vecs[i].name, vecs[i].exp});
            step();
            sb_pop_check();
            step();
            exp_cnt = exp_cnt + 16'd1;
        end
        check_cnt("cnt_after_table");

        // Reset in the middle of EXECUTE aborts the instruction
        F = 4'h0;
        step();
        reset = 1'b1;
        #1;
        check_w("rst_mid_exec", W_ZERO);
        step();
        reset = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        check_w("fetch_after_rst", w_fetch);
        check_cnt("cnt_after_rst");

        // STP, then HALT held with counter frozen
        F = 4'h7;
        #1;
        step();
        check_w("stp_exec", W_ZERO);
        step();
        exp_cnt = exp_cnt + 16'd1;
        check_w("halted", cw(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
        check_cnt("cnt_halt");
        F = 4'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_w("halt_hold", cw(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
        end
        check_cnt("cnt_frozen");
        reset = 1'b1;
        #1;
        check_w("rst_in_halt", W_ZERO);
        step();
        reset = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        check_w("fetch_after_halt", w_fetch);
        check_cnt("cnt_after_halt");

        // Counter wrap: 65535 no-ops reach FFFF, one more wraps to 0000
        F = 4'h8;
        for (int i = 0; i < 65535; i++) begin
            step();
            step();
        end
        exp_cnt = 16'hFFFF;
        check_cnt("cnt_ffff");
        step();
        step();
        exp_cnt = 16'h0000;
        check_cnt("cnt_wrap");
        check_w("fetch_after_wrap", w_fetch);

`ifdef MU0_MEM_WAIT_EN
        // STA held by three wait cycles, then commits on the ready cycle
        F = 4'h1;
        step();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_w("sta_wait", cw(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0));
            check_cnt("cnt_sta_wait");
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_w("sta_ready", cw(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0));
        step();
        exp_cnt = exp_cnt + 16'd1;
        check_w("fetch_after_sta", w_fetch);
        check_cnt("cnt_after_sta");

        // FETCH stalled two cycles keeps IR/PC loads off until ready
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_w("fetch_wait", cw(1, 0, 0, 2'b10, 0, 0, 0, 1, 0, 0));
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_w("fetch_ready", w_fetch);
        F = 4'h4;
        step();
        mem_ready = 1'b0;
        #1;
        check_w("jmp_ignores_wait", cw(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0));
        step();
        mem_ready = 1'b1;
        #1;
        exp_cnt = exp_cnt + 16'd1;
        check_w("fetch_after_jmp", w_fetch);
        check_cnt("cnt_after_jmp");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
